// File: rtl/store_write_buffer_pkg.sv
// ============================================================================
// Module  : store_write_buffer_pkg
// Brief   : Shared types and constants for the store write buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package store_write_buffer_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        OP_STORE = 2'd0,
        OP_SWL   = 2'd1,
        OP_SWR   = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    // Supported store bus widths; only the wide bus can carry a doubleword.
    localparam int c_data_w_narrow = 32;
    localparam int c_data_w_wide   = 64;

endpackage

`default_nettype wire

// File: rtl/store_lane_align.sv
// ============================================================================
// Module  : store_lane_align
// Brief   : Combinational lane alignment, byte strobes and misalign detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_lane_align
    import store_write_buffer_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    localparam int B      = DATA_W / 8,
    localparam int LB     = $clog2(B)
) (
    input  logic [ADDR_W-1:0] addr,
    input  msize_t            msize,
    input  op_t               op,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] adata,
    output logic [B-1:0]      strb,
    output logic              misalign
);

    logic [LB-1:0] w_o;
    logic [1:0]    w_w;
    logic          w_k;
    logic [31:0]   w_word;
    logic [3:0]    w_nib;
    logic          w_use_word;
    logic          w_unused;

    assign w_o      = addr[LB-1:0];
    assign w_w      = addr[1:0];
    assign w_k      = (B == 8) ? addr[2] : 1'b0;
    assign w_unused = ^addr[ADDR_W-1:3];

    always_comb begin
        adata      = '0;
        strb       = '0;
        misalign   = 1'b0;
        w_word     = '0;
        w_nib      = '0;
        w_use_word = 1'b0;
        if (op == OP_SWL) begin
            // Left partial word: the register's high bytes land at bytes 0..w.
            w_use_word = 1'b1;
            case (w_w)
                2'd0:    begin w_word = {24'b0, data[31:24]}; w_nib = 4'b0001; end
                2'd1:    begin w_word = {16'b0, data[31:16]}; w_nib = 4'b0011; end
                2'd2:    begin w_word = {8'b0,  data[31:8]};  w_nib = 4'b0111; end
                default: begin w_word = data[31:0];           w_nib = 4'b1111; end
            endcase
        end else if (op == OP_SWR) begin
            w_use_word = 1'b1;
            case (w_w)
                2'd0:    begin w_word = data[31:0];           w_nib = 4'b1111; end
                2'd1:    begin w_word = {data[23:0], 8'b0};   w_nib = 4'b1110; end
                2'd2:    begin w_word = {data[15:0], 16'b0};  w_nib = 4'b1100; end
                default: begin w_word = {data[7:0], 24'b0};   w_nib = 4'b1000; end
            endcase
        end else begin
            case (msize)
                MSIZE1: begin
                    adata[8*w_o +: 8] = data[7:0];
                    strb[w_o]         = 1'b1;
                end
                MSIZE2: begin
                    if (addr[0]) begin
                        misalign = 1'b1;
                    end else begin
                        adata[8*w_o +: 16] = data[15:0];
                        strb[w_o +: 2]     = 2'b11;
                    end
                end
                MSIZE4: begin
                    if (w_w != 2'd0) begin
                        misalign = 1'b1;
                    end else begin
                        w_use_word = 1'b1;
                        w_word     = data[31:0];
                        w_nib      = 4'b1111;
                    end
                end
                default: begin
                    if (DATA_W == c_data_w_wide && addr[2:0] == 3'd0) begin
                        adata = data;
                        strb  = '1;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            endcase
        end
        if (w_use_word) begin
            adata[32*w_k +: 32] = w_word;
            strb[4*w_k +: 4]    = w_nib;
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_write_buffer.sv
// ============================================================================
// Module  : store_write_buffer
// Brief   : Committed-store FIFO with lane alignment, misalign error and hit check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 32,
    localparam int B      = DATA_W / 8,
    localparam int LB     = $clog2(B),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  msize_t            in_msize,
    input  op_t               in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [B-1:0]      out_strb,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_hit,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [PW:0]       count
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [B-1:0]      strb;
    } store_entry_t;

    store_entry_t      r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;

    logic [DATA_W-1:0] w_adata;
    logic [B-1:0]      w_strb;
    logic              w_misalign;
    logic              w_accept;
    logic              w_enq;
    logic              w_deq;
    logic              w_hit;
    store_entry_t      w_entry;
    store_entry_t      w_head;
    logic              w_unused;

    store_lane_align #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_align (
        .addr     (in_addr),
        .msize    (in_msize),
        .op       (in_op),
        .data     (in_data),
        .adata    (w_adata),
        .strb     (w_strb),
        .misalign (w_misalign)
    );

    // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
    assign in_ready  = ~r_count[PW];
    assign out_valid = |r_count;
    assign w_accept  = in_valid & in_ready;
    assign w_enq     = w_accept & ~w_misalign;
    assign w_deq     = out_valid & out_ready;

    assign w_entry.addr = {in_addr[ADDR_W-1:LB], {LB{1'b0}}};
    assign w_entry.data = w_adata;
    assign w_entry.strb = w_strb;

    assign w_head    = r_mem[r_rd_ptr];
    assign out_addr  = out_valid ? w_head.addr : '0;
    assign out_data  = out_valid ? w_head.data : '0;
    assign out_strb  = out_valid ? w_head.strb : '0;
    assign count     = r_count;
    assign err       = r_err;
    assign err_addr  = r_err_addr;
    assign chk_hit   = w_hit;
    assign w_unused  = ^chk_addr[LB-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            if (w_enq) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_err <= w_accept & w_misalign;
            if (w_accept && w_misalign) begin
                r_err_addr <= in_addr;
            end
        end
    end

    // Payload storage needs no reset: every read is qualified by a valid bit.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_mem[i].addr[ADDR_W-1:LB] == chk_addr[ADDR_W-1:LB])) begin
                w_hit = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_write_buffer.sv
// ============================================================================
// Module  : tb_store_write_buffer
// Brief   : Scoreboard bench for 32-bit and 64-bit store write buffer instances.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_write_buffer;
    import store_write_buffer_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    // 32-bit instance
    logic        a_rst = 1'b1, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [31:0] a_in_addr = '0, a_in_data = '0, a_chk_addr = '0;
    msize_t      a_in_msize = MSIZE1;
    op_t         a_in_op = OP_STORE;
    logic        a_in_ready, a_out_valid, a_chk_hit, a_err;
    logic [31:0] a_out_addr, a_out_data, a_err_addr;
    logic [3:0]  a_out_strb;
    logic [2:0]  a_count;

    // 64-bit instance
    logic        b_rst = 1'b1, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_in_addr = '0, b_chk_addr = '0;
    logic [63:0] b_in_data = '0;
    msize_t      b_in_msize = MSIZE1;
    op_t         b_in_op = OP_STORE;
    logic        b_in_ready, b_out_valid, b_chk_hit, b_err;
    logic [31:0] b_out_addr, b_err_addr;
    logic [63:0] b_out_data;
    logic [7:0]  b_out_strb;
    logic [2:0]  b_count;

    store_write_buffer #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) dut_a (
        .clk(clk), .reset(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_addr(a_in_addr), .in_msize(a_in_msize), .in_op(a_in_op), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr),
        .out_data(a_out_data), .out_strb(a_out_strb), .chk_addr(a_chk_addr),
        .chk_hit(a_chk_hit), .err(a_err), .err_addr(a_err_addr), .count(a_count)
    );

    store_write_buffer #(.DATA_W(64), .DEPTH(4), .ADDR_W(32)) dut_b (
        .clk(clk), .reset(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_addr(b_in_addr), .in_msize(b_in_msize), .in_op(b_in_op), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr),
        .out_data(b_out_data), .out_strb(b_out_strb), .chk_addr(b_chk_addr),
        .chk_hit(b_chk_hit), .err(b_err), .err_addr(b_err_addr), .count(b_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: compare each head entry as it is handed to the cache.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_out", {32'b0, a_out_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_out_addr", {32'b0, a_out_addr}, {32'b0, e.addr});
                chk("a_out_data", {32'b0, a_out_data}, e.data);
                chk("a_out_strb", {60'b0, a_out_strb}, {56'b0, e.strb});
            end
        end
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_out", {32'b0, b_out_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_out_addr", {32'b0, b_out_addr}, {32'b0, e.addr});
                chk("b_out_data", b_out_data, e.data);
                chk("b_out_strb", {56'b0, b_out_strb}, {56'b0, e.strb});
            end
        end
    end

    // Drive one request for one cycle; called just after a rising edge.
    task automatic drive_a(input logic [31:0] addr, input msize_t ms, input op_t op,
                           input logic [31:0] data);
        a_in_valid = 1'b1; a_in_addr = addr; a_in_msize = ms; a_in_op = op; a_in_data = data;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [31:0] addr, input msize_t ms, input op_t op,
                           input logic [63:0] data);
        b_in_valid = 1'b1; b_in_addr = addr; b_in_msize = ms; b_in_op = op; b_in_data = data;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] addr, input msize_t ms, input op_t op,
                          input logic [31:0] data, input logic [31:0] ea,
                          input logic [31:0] ed, input logic [3:0] es);
        q_a.push_back('{addr: ea, data: {32'b0, ed}, strb: {4'b0, es}});
        drive_a(addr, ms, op, data);
    endtask

    task automatic push_b(input logic [31:0] addr, input msize_t ms, input op_t op,
                          input logic [63:0] data, input logic [31:0] ea,
                          input logic [63:0] ed, input logic [7:0] es);
        q_b.push_back('{addr: ea, data: ed, strb: es});
        drive_b(addr, ms, op, data);
    endtask

    initial begin
        // Reset values
        @(posedge clk); @(negedge clk);
        chk("a_rst_count",     {61'b0, a_count}, 64'd0);
        chk("a_rst_out_valid", {63'b0, a_out_valid}, 64'd0);
        chk("a_rst_in_ready",  {63'b0, a_in_ready}, 64'd1);
        chk("a_rst_err",       {63'b0, a_err}, 64'd0);
        chk("a_rst_err_addr",  {32'b0, a_err_addr}, 64'd0);
        chk("a_rst_out_data",  {32'b0, a_out_data}, 64'd0);
        chk("a_rst_out_strb",  {60'b0, a_out_strb}, 64'd0);
        chk("a_rst_out_addr",  {32'b0, a_out_addr}, 64'd0);
        chk("a_rst_chk_hit",   {63'b0, a_chk_hit}, 64'd0);
        chk("b_rst_out_valid", {63'b0, b_out_valid}, 64'd0);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;

        // 64-bit bus: partial words, doubleword, lane placement
        push_b(32'h2005, MSIZE4, OP_SWL, 64'h11223344, 32'h2000, 64'h00001122_00000000, 8'b0011_0000);
        push_b(32'h2005, MSIZE4, OP_SWR, 64'h11223344, 32'h2000, 64'h22334400_00000000, 8'b1110_0000);
        push_b(32'h2008, MSIZE8, OP_STORE, 64'h01234567_89ABCDEF, 32'h2008, 64'h01234567_89ABCDEF, 8'hFF);
        push_b(32'h2006, MSIZE1, OP_STORE, 64'hCD, 32'h2000, 64'h00CD0000_00000000, 8'b0100_0000);
        push_b(32'h2002, MSIZE2, OP_STORE, 64'hBEEF, 32'h2000, 64'h00000000_BEEF0000, 8'b0000_1100);
        push_b(32'h2004, MSIZE4, OP_STORE, 64'hCAFEF00D, 32'h2000, 64'hCAFEF00D_00000000, 8'hF0);
        drive_b(32'h200C, MSIZE8, OP_STORE, 64'h55);
        @(negedge clk);
        chk("b_sd_misalign_err",  {63'b0, b_err}, 64'd1);
        chk("b_sd_misalign_addr", {32'b0, b_err_addr}, 64'h200C);

        // 32-bit bus: first store must not bypass, then appears one cycle later
        @(posedge clk); #1;
        q_a.push_back('{addr: 32'h1000, data: 64'hAB000000, strb: 8'b1000});
        a_in_valid = 1'b1; a_in_addr = 32'h1003; a_in_msize = MSIZE1; a_in_op = OP_STORE;
        a_in_data = 32'hAB;
        @(negedge clk);
        chk("a_no_bypass", {63'b0, a_out_valid}, 64'd0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("a_latency_valid", {63'b0, a_out_valid}, 64'd1);
        @(posedge clk); #1;
        push_a(32'h1002, MSIZE2, OP_STORE, 32'h12345678, 32'h1000, 32'h56780000, 4'b1100);
        push_a(32'h1004, MSIZE4, OP_STORE, 32'hDEADBEEF, 32'h1004, 32'hDEADBEEF, 4'b1111);
        push_a(32'h1006, MSIZE4, OP_SWL, 32'h11223344, 32'h1004, 32'h00112233, 4'b0111);
        push_a(32'h1006, MSIZE4, OP_SWR, 32'h11223344, 32'h1004, 32'h33440000, 4'b1100);
        drive_a(32'h1008, MSIZE8, OP_STORE, 32'h99);
        @(negedge clk);
        chk("a_sd_narrow_err",  {63'b0, a_err}, 64'd1);
        chk("a_sd_narrow_addr", {32'b0, a_err_addr}, 64'h1008);
        repeat (4) @(posedge clk);
        #1;
        chk("a_drained_count", {61'b0, a_count}, 64'd0);

        // Misaligned halfword while one entry is buffered
        a_out_ready = 1'b0;
        push_a(32'h5000, MSIZE4, OP_STORE, 32'h01010101, 32'h5000, 32'h01010101, 4'hF);
        drive_a(32'h3001, MSIZE2, OP_STORE, 32'hFFFF);
        @(negedge clk);
        chk("a_misalign_err",       {63'b0, a_err}, 64'd1);
        chk("a_misalign_err_addr",  {32'b0, a_err_addr}, 64'h3001);
        chk("a_misalign_count",     {61'b0, a_count}, 64'd1);
        chk("a_misalign_out_valid", {63'b0, a_out_valid}, 64'd1);
        @(negedge clk);
        chk("a_err_one_cycle", {63'b0, a_err}, 64'd0);
        @(posedge clk); #1;

        // Fill to full, then one cycle with dequeue and a blocked enqueue
        push_a(32'h5004, MSIZE4, OP_STORE, 32'h02020202, 32'h5004, 32'h02020202, 4'hF);
        push_a(32'h5008, MSIZE4, OP_STORE, 32'h03030303, 32'h5008, 32'h03030303, 4'hF);
        push_a(32'h500C, MSIZE4, OP_STORE, 32'h04040404, 32'h500C, 32'h04040404, 4'hF);
        @(negedge clk);
        chk("a_full_count",    {61'b0, a_count}, 64'd4);
        chk("a_full_in_ready", {63'b0, a_in_ready}, 64'd0);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_addr = 32'h6000; a_in_msize = MSIZE4; a_in_op = OP_STORE;
        a_in_data = 32'hEEEEEEEE;
        @(negedge clk);
        chk("a_full_ready_low", {63'b0, a_in_ready}, 64'd0);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        @(negedge clk);
        chk("a_after_deq_count", {61'b0, a_count}, 64'd3);
        chk("a_after_deq_ready", {63'b0, a_in_ready}, 64'd1);
        @(posedge clk); #1;
        push_a(32'h5010, MSIZE4, OP_STORE, 32'h05050505, 32'h5010, 32'h05050505, 4'hF);
        a_out_ready = 1'b1;
        for (int i = 0; i < 20 && a_count != 0; i++) @(posedge clk);
        #1;
        chk("a_wrap_drained", {61'b0, a_count}, 64'd0);

        // Address hit check, then asynchronous reset while full
        a_out_ready = 1'b0;
        push_a(32'h4008, MSIZE4, OP_STORE, 32'h77777777, 32'h4008, 32'h77777777, 4'hF);
        a_chk_addr = 32'h400A;
        @(negedge clk);
        chk("a_hit_same_word", {63'b0, a_chk_hit}, 64'd1);
        a_chk_addr = 32'h400C;
        #1;
        chk("a_hit_next_word", {63'b0, a_chk_hit}, 64'd0);
        a_chk_addr = 32'h400A;
        @(posedge clk); #1;
        push_a(32'h7000, MSIZE4, OP_STORE, 32'h1, 32'h7000, 32'h1, 4'hF);
        push_a(32'h7004, MSIZE4, OP_STORE, 32'h2, 32'h7004, 32'h2, 4'hF);
        push_a(32'h7008, MSIZE4, OP_STORE, 32'h3, 32'h7008, 32'h3, 4'hF);
        @(negedge clk);
        chk("a_prereset_count", {61'b0, a_count}, 64'd4);
        #2;
        a_rst = 1'b1;
        #1;
        chk("a_midrst_out_valid", {63'b0, a_out_valid}, 64'd0);
        chk("a_midrst_count",     {61'b0, a_count}, 64'd0);
        chk("a_midrst_chk_hit",   {63'b0, a_chk_hit}, 64'd0);
        chk("a_midrst_in_ready",  {63'b0, a_in_ready}, 64'd1);
        q_a.delete();
        @(posedge clk); #1;
        a_rst = 1'b0;

        for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
        chk("a_queue_empty", 64'(q_a.size()), 64'd0);
        chk("b_queue_empty", 64'(q_b.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
